load_store_ctrl: RTL and testbench

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

---
 rtl/lsu_pkg.sv | 74 +++++++
 rtl/read_data.sv | 33 +++
 rtl/load_store_ctrl.sv | 147 ++++++++++++++
 tb/tb_load_store_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and request helpers for the load/store controller
package lsu_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LBU = 3'b001,
        LT_LB  = 3'b010,
        LT_LHU = 3'b100,
        LT_LH  = 3'b101
    } load_type_e;

    typedef enum logic [1:0] {
        ST_SW = 2'b00,
        ST_SB = 2'b01,
        ST_SH = 2'b10
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } lsu_state_e;

    // A request is legal when its type encoding exists and the address is
    // naturally aligned for the access size.
    function automatic logic req_legal(input logic       is_store,
                                       input logic [2:0] lt,
                                       input logic [1:0] st,
                                       input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (store_type_e'(st))
                ST_SW:   ok = (lo == 2'b00);
                ST_SB:   ok = 1'b1;
                ST_SH:   ok = ~lo[0];
                default: ok = 1'b0;
            endcase
        end else begin
            case (load_type_e'(lt))
                LT_LW:          ok = (lo == 2'b00);
                LT_LBU, LT_LB:  ok = 1'b1;
                LT_LHU, LT_LH:  ok = ~lo[0];
                default:        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Byte enables for a store, shifted to the addressed lane.
    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] lo);
        logic [3:0] be;
        case (store_type_e'(st))
            ST_SB:   be = 4'b0001 << lo;
            ST_SH:   be = 4'b0011 << lo;
            ST_SW:   be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the enabled lane carries it.
    function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] d);
        logic [31:0] w;
        case (store_type_e'(st))
            ST_SB:   w = {4{d[7:0]}};
            ST_SH:   w = {2{d[15:0]}};
            ST_SW:   w = d;
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/read_data.sv
// rtl/read_data.sv - selects and extends the addressed byte/half of a loaded word
module read_data
    import lsu_pkg::*;
(
    input  logic [1:0]  Addr,
    input  logic [2:0]  LoadType,
    input  logic [31:0] ReadData,
    output logic [31:0] ReadDataOut
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then zero or sign extend it by load type.
    always_comb begin
        byte_sel = ReadData[7:0];
        case (Addr)
            2'b00:   byte_sel = ReadData[7:0];
            2'b01:   byte_sel = ReadData[15:8];
            2'b10:   byte_sel = ReadData[23:16];
            default: byte_sel = ReadData[31:24];
        endcase
        half_sel = Addr[1] ? ReadData[31:16] : ReadData[15:0];
        case (load_type_e'(LoadType))
            LT_LBU:  ReadDataOut = {24'h0, byte_sel};
            LT_LB:   ReadDataOut = {{24{byte_sel[7]}}, byte_sel};
            LT_LHU:  ReadDataOut = {16'h0, half_sel};
            LT_LH:   ReadDataOut = {{16{half_sel[15]}}, half_sel};
            default: ReadDataOut = ReadData;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - single-outstanding CPU load/store to word memory controller
module load_store_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [2:0]  LoadType,
    input  logic [1:0]  StoreType,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespErr,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBE,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        write_q, write_d;
    logic [2:0]  load_type_q, load_type_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] load_fmt;

    read_data u_read_data (
        .Addr        (addr_lo_q),
        .LoadType    (load_type_q),
        .ReadData    (MemRData),
        .ReadDataOut (load_fmt)
    );

    // Memory-side strobes are only meaningful while the access is in flight.
    assign ReqReady  = (state_q == S_IDLE);
    assign RespValid = (state_q == S_RESP);
    assign MemReq    = (state_q == S_ACCESS);
    assign MemWE     = mem_we_q & MemReq;
    assign MemBE     = MemReq ? mem_be_q : 4'b0000;
    assign MemAddr   = mem_addr_q;
    assign MemWData  = mem_wdata_q;
    assign RespData  = resp_data_q;
    assign RespErr   = resp_err_q;
    assign Stall     = (state_q != S_IDLE) | (ReqValid & (state_q == S_IDLE));

    // Next-state and datapath: accept, run the access with timeout, respond once.
    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        write_d     = write_q;
        load_type_d = load_type_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_we_d    = mem_we_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    addr_lo_d   = ReqAddr[1:0];
                    write_d     = ReqWrite;
                    load_type_d = LoadType;
                    if (req_legal(ReqWrite, LoadType, StoreType, ReqAddr[1:0])) begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        mem_addr_d  = {ReqAddr[31:2], 2'b00};
                        mem_we_d    = ReqWrite;
                        mem_be_d    = ReqWrite ? store_be(StoreType, ReqAddr[1:0]) : 4'b0000;
                        mem_wdata_d = ReqWrite ? store_wdata(StoreType, ReqWData) : 32'h0;
                    end else begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = 32'h0;
                    end
                end
            end
            S_ACCESS: begin
                if (MemAck) begin
                    state_d     = S_RESP;
                    resp_err_d  = 1'b0;
                    resp_data_d = write_q ? 32'h0 : load_fmt;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_RESP;
                    resp_err_d  = 1'b1;
                    resp_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_lo_q   <= 2'b00;
            write_q     <= 1'b0;
            load_type_q <= 3'b000;
            cnt_q       <= '0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_we_q    <= 1'b0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            write_q     <= write_d;
            load_type_q <= load_type_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - randomized self-checking bench for load_store_ctrl
module tb_load_store_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [31:0] ReqAddr, ReqWData;
    logic [2:0]  LoadType;
    logic [1:0]  StoreType;
    logic        RespValid, RespErr, Stall;
    logic [31:0] RespData;
    logic        MemReq, MemWE, MemAck;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic [3:0]  MemBE;

    int tests_run    = 0;
    int tests_failed = 0;

    load_store_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .LoadType(LoadType), .StoreType(StoreType),
        .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr), .Stall(Stall),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBE(MemBE), .MemAck(MemAck), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes from the type encoding (0 = illegal).
    function automatic int m_size(input logic wr, input logic [2:0] lt, input logic [1:0] st);
        if (wr) return (st == 2'd0) ? 4 : (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 0;
        case (lt)
            3'b000:         return 4;
            3'b001, 3'b010: return 1;
            3'b100, 3'b101: return 2;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_legal(input logic wr, input logic [2:0] lt, input logic [1:0] st,
                                     input logic [31:0] addr);
        int s;
        s = m_size(wr, lt, st);
        return (s != 0) && ((addr % s) == 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] addr,
                                           input logic [31:0] word);
        int s;
        logic [31:0] v;
        s = m_size(1'b0, lt, 2'd0);
        v = word >> (8 * (addr % 4));
        if (s == 1) begin
            v = v & 32'hff;
            if (lt == 3'b010 && v >= 32'h80) v = v - 32'h100;
        end else if (s == 2) begin
            v = v & 32'hffff;
            if (lt == 3'b101 && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] st, input logic [31:0] addr);
        int s;
        s = m_size(1'b1, 3'b000, st);
        return 4'(((1 << s) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] wd);
        int s;
        s = m_size(1'b1, 3'b000, st);
        if (s == 1) return (wd & 32'hff) * 32'h01010101;
        if (s == 2) return (wd & 32'hffff) * 32'h00010001;
        return wd;
    endfunction

    // Observations gathered by do_txn.
    logic        ob_resp, ob_rerr, ob_mreq_seen, ob_mreq_at_resp, ob_stable, ob_rdy, ob_one_cycle, ob_we;
    int          ob_lat;
    logic [31:0] ob_rdata, ob_maddr, ob_mwdata;
    logic [3:0]  ob_be;

    // Drives one request, acks after ack_wait unacked ACCESS cycles (-1 = never), records behaviour.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] lt, input logic [1:0] st, input int ack_wait,
                          input logic [31:0] rdata);
        int k;
        @(negedge clk);
        ob_rdy   = ReqReady;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqWData = wd; LoadType = lt; StoreType = st;
        @(posedge clk);
        #1;
        ReqValid = 1'b0; ReqAddr = $urandom; ReqWData = $urandom;
        ReqWrite = 1'($urandom); LoadType = 3'($urandom); StoreType = 2'($urandom);
        ob_resp = 1'b0; ob_mreq_seen = 1'b0; ob_stable = 1'b1; ob_lat = 0; k = 0;
        ob_rdata = 32'h0; ob_rerr = 1'b0; ob_mreq_at_resp = 1'b1;
        ob_maddr = 32'h0; ob_mwdata = 32'h0; ob_be = 4'h0; ob_we = 1'b0;
        for (int c = 1; c <= 40 && !ob_resp; c++) begin
            @(negedge clk);
            MemAck = 1'b0;
            if (RespValid) begin
                ob_resp = 1'b1; ob_lat = c; ob_rdata = RespData; ob_rerr = RespErr; ob_mreq_at_resp = MemReq;
            end else if (MemReq) begin
                if (!ob_mreq_seen) begin
                    ob_maddr = MemAddr; ob_mwdata = MemWData; ob_be = MemBE; ob_we = MemWE;
                end else if (MemAddr !== ob_maddr || MemWData !== ob_mwdata || MemBE !== ob_be || MemWE !== ob_we) begin
                    ob_stable = 1'b0;
                end
                ob_mreq_seen = 1'b1;
                if (k == ack_wait) begin
                    MemAck = 1'b1; MemRData = rdata;
                end
                k++;
            end
        end
        MemAck = 1'b0; MemRData = $urandom;
        @(negedge clk);
        ob_one_cycle = !RespValid && ReqReady;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++; if (ReqReady !== 1'b1) begin tests_failed++; $display("FAIL reset ReqReady: got %b expected 1", ReqReady); end
        tests_run++; if ({MemReq, MemWE, RespValid, RespErr} !== 4'b0000) begin tests_failed++; $display("FAIL reset strobes: got %b expected 0000", {MemReq, MemWE, RespValid, RespErr}); end
        tests_run++; if (MemBE !== 4'b0000) begin tests_failed++; $display("FAIL reset MemBE: got %b expected 0000", MemBE); end
        tests_run++; if ({RespData, MemAddr, MemWData} !== 96'h0) begin tests_failed++; $display("FAIL reset data: got %h %h %h expected zeros", RespData, MemAddr, MemWData); end
        tests_run++; if (Stall !== 1'b0) begin tests_failed++; $display("FAIL reset Stall: got %b expected 0", Stall); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h0; LoadType = 3'b000;
        #1;
        tests_run++; if (Stall !== 1'b1) begin tests_failed++; $display("FAIL idle_req Stall: got %b expected 1", Stall); end
        ReqValid = 1'b0;
        #1;
    endtask

    task automatic test_vectors();
        do_txn(1'b0, 32'h100, 32'h0, 3'b000, 2'd0, 2, 32'ha5b4c3d2);
        tests_run++; if (ob_rdata !== 32'ha5b4c3d2 || ob_rerr !== 1'b0) begin tests_failed++; $display("FAIL lw_0x100 resp: got %h err %b expected a5b4c3d2 err 0", ob_rdata, ob_rerr); end
        tests_run++; if (ob_be !== 4'b0000 || ob_we !== 1'b0 || ob_maddr !== 32'h100) begin tests_failed++; $display("FAIL lw_0x100 mem: got be %b we %b addr %h expected 0000 0 100", ob_be, ob_we, ob_maddr); end
        tests_run++; if (ob_lat !== 4) begin tests_failed++; $display("FAIL lw_0x100 latency: got %0d expected 4", ob_lat); end
        do_txn(1'b0, 32'h3, 32'h0, 3'b001, 2'd0, 0, 32'ha5b4c3d2);
        tests_run++; if (ob_rdata !== 32'h000000a5 || ob_lat !== 2) begin tests_failed++; $display("FAIL lbu_3: got %h lat %0d expected 000000a5 lat 2", ob_rdata, ob_lat); end
        do_txn(1'b0, 32'h3, 32'h0, 3'b010, 2'd0, 0, 32'ha5b4c3d2);
        tests_run++; if (ob_rdata !== 32'hffffffa5) begin tests_failed++; $display("FAIL lb_3: got %h expected ffffffa5", ob_rdata); end
        do_txn(1'b0, 32'h2, 32'h0, 3'b101, 2'd0, 0, 32'ha5b4c3d2);
        tests_run++; if (ob_rdata !== 32'hffffa5b4) begin tests_failed++; $display("FAIL lh_2: got %h expected ffffa5b4", ob_rdata); end
        do_txn(1'b1, 32'h6, 32'h00001234, 3'b000, 2'd2, 1, 32'hdeadbeef);
        tests_run++; if (ob_maddr !== 32'h4 || ob_be !== 4'b1100) begin tests_failed++; $display("FAIL sh_6 addr/be: got %h %b expected 00000004 1100", ob_maddr, ob_be); end
        tests_run++; if (ob_mwdata !== 32'h12341234 || ob_we !== 1'b1) begin tests_failed++; $display("FAIL sh_6 wdata/we: got %h %b expected 12341234 1", ob_mwdata, ob_we); end
        tests_run++; if (ob_rdata !== 32'h0 || ob_rerr !== 1'b0 || ob_stable !== 1'b1) begin tests_failed++; $display("FAIL sh_6 resp: got %h err %b stable %b expected 0 0 1", ob_rdata, ob_rerr, ob_stable); end
        do_txn(1'b0, 32'h1, 32'h0, 3'b000, 2'd0, 0, 32'h0);
        tests_run++; if (ob_lat !== 1 || ob_rerr !== 1'b1) begin tests_failed++; $display("FAIL lw_misaligned: got lat %0d err %b expected 1 1", ob_lat, ob_rerr); end
        tests_run++; if (ob_mreq_seen !== 1'b0) begin tests_failed++; $display("FAIL lw_misaligned MemReq: got %b expected 0", ob_mreq_seen); end
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 32'h40, 32'h0, 3'b000, 2'd0, -1, 32'h0);
        tests_run++; if (ob_lat !== TO + 1 || ob_rerr !== 1'b1 || ob_rdata !== 32'h0) begin tests_failed++; $display("FAIL timeout: got lat %0d err %b data %h expected %0d 1 0", ob_lat, ob_rerr, ob_rdata, TO + 1); end
        tests_run++; if (ob_mreq_at_resp !== 1'b0 || ob_one_cycle !== 1'b1) begin tests_failed++; $display("FAIL timeout drop: got mreq %b one_cycle %b expected 0 1", ob_mreq_at_resp, ob_one_cycle); end
        do_txn(1'b0, 32'h44, 32'h0, 3'b100, 2'd0, TO - 1, 32'h87654321);
        tests_run++; if (ob_lat !== TO + 1 || ob_rerr !== 1'b0 || ob_rdata !== 32'h00004321) begin tests_failed++; $display("FAIL ack_on_timeout: got lat %0d err %b data %h expected %0d 0 00004321", ob_lat, ob_rerr, ob_rdata, TO + 1); end
    endtask

    task automatic test_reset_mid_access();
        int seen;
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h200; LoadType = 3'b000;
        @(posedge clk);
        #1 ReqValid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (MemReq !== 1'b1) begin tests_failed++; $display("FAIL mid_access MemReq before reset: got %b expected 1", MemReq); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (MemReq !== 1'b0 || RespValid !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_access async: got mreq %b rvalid %b expected 0 0", MemReq, RespValid); end
        @(negedge clk);
        reset = 1'b0;
        MemAck = 1'b1; MemRData = 32'h11111111;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (RespValid || MemReq || !ReqReady) seen++;
        end
        MemAck = 1'b0;
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL reset_mid_access aftermath: got %0d busy cycles expected 0", seen); end
        tests_run++; if (ReqReady !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_access ReqReady: got %b expected 1", ReqReady); end
    endtask

    task automatic test_back_to_back();
        int nresp;
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h301; LoadType = 3'b001;
        MemRData = 32'ha5b4c3d2;
        nresp = 0;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            MemAck = MemReq;
            if (RespValid) begin
                nresp++;
                tests_run++; if (RespData !== 32'h000000c3) begin tests_failed++; $display("FAIL b2b data[%0d]: got %h expected 000000c3", c, RespData); end
            end
            tests_run++; if (RespValid !== (c % 3 == 2) || ReqReady !== (c % 3 == 0)) begin tests_failed++; $display("FAIL b2b handshake[%0d]: got rv %b rdy %b expected %b %b", c, RespValid, ReqReady, c % 3 == 2, c % 3 == 0); end
            tests_run++; if (Stall !== 1'b1) begin tests_failed++; $display("FAIL b2b stall[%0d]: got %b expected 1", c, Stall); end
        end
        ReqValid = 1'b0; MemAck = 1'b0;
        tests_run++; if (nresp !== 3) begin tests_failed++; $display("FAIL b2b count: got %0d expected 3", nresp); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  lt_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic        wr, legal;
        logic [31:0] addr, wd, rdata, exp_data;
        logic [2:0]  lt;
        logic [1:0]  st;
        int          aw, exp_lat;
        for (int i = 0; i < 60; i++) begin
            wr    = 1'($urandom);
            addr  = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd    = $urandom;
            lt    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : lt_tab[$urandom_range(0, 4)];
            st    = 2'($urandom);
            aw    = $urandom_range(0, 3);
            rdata = $urandom;
            legal = m_legal(wr, lt, st, addr);
            exp_lat  = legal ? aw + 2 : 1;
            exp_data = (legal && !wr) ? m_load(lt, addr, rdata) : 32'h0;
            do_txn(wr, addr, wd, lt, st, aw, rdata);
            tests_run++; if (ob_resp !== 1'b1 || ob_lat !== exp_lat || ob_rdy !== 1'b1) begin tests_failed++; $display("FAIL rand[%0d] timing: got resp %b lat %0d rdy %b expected 1 %0d 1", i, ob_resp, ob_lat, ob_rdy, exp_lat); end
            tests_run++; if (ob_rerr !== !legal || ob_rdata !== exp_data) begin tests_failed++; $display("FAIL rand[%0d] resp: got err %b data %h expected %b %h", i, ob_rerr, ob_rdata, !legal, exp_data); end
            tests_run++; if (ob_mreq_seen !== legal || ob_one_cycle !== 1'b1) begin tests_failed++; $display("FAIL rand[%0d] mreq/onecycle: got %b %b expected %b 1", i, ob_mreq_seen, ob_one_cycle, legal); end
            if (legal) begin
                tests_run++; if (ob_maddr !== (addr & 32'hfffffffc) || ob_we !== wr || ob_stable !== 1'b1 || ob_mreq_at_resp !== 1'b0) begin tests_failed++; $display("FAIL rand[%0d] mem: got addr %h we %b stable %b mreq_resp %b expected %h %b 1 0", i, ob_maddr, ob_we, ob_stable, ob_mreq_at_resp, addr & 32'hfffffffc, wr); end
                tests_run++; if (ob_be !== (wr ? m_be(st, addr) : 4'b0000)) begin tests_failed++; $display("FAIL rand[%0d] be: got %b expected %b", i, ob_be, wr ? m_be(st, addr) : 4'b0000); end
                if (wr) begin
                    tests_run++; if (ob_mwdata !== m_wdata(st, wd)) begin tests_failed++; $display("FAIL rand[%0d] wdata: got %h expected %h", i, ob_mwdata, m_wdata(st, wd)); end
                end
            end
        end
    endtask

    initial begin
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = 32'h0; ReqWData = 32'h0;
        LoadType = 3'b000; StoreType = 2'b00; MemAck = 1'b0; MemRData = 32'h0;
        test_reset();
        test_vectors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
